// File: rtl/instr_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode constants, format codes and the
// decoded-entry structs passed between the field decoder and the stage.
package riscv_defs;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [6:0]  opcode;
    dec_t        dec;
    logic [31:0] pc;
  } entry_t;

  function automatic fmt_e opFmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_OP:                      f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:   f = FMT_I;
      OP_STORE:                   f = FMT_S;
      OP_BRANCH:                  f = FMT_B;
      OP_LUI, OP_AUIPC:           f = FMT_U;
      OP_JAL:                     f = FMT_J;
      default:                    f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational RV32I field extractor: classifies by opcode and pulls out
// register indices, funct fields and the sign-extended immediate.
module instr_field_decode
  import riscv_defs::*;
(
  input  logic [31:0] iINSTR,
  output dec_t        oDEC
);

  logic [31:0] ins;
  assign ins = iINSTR;

  always_comb begin
    oDEC     = '0;
    oDEC.fmt = opFmt(ins[6:0]);
    case (oDEC.fmt)
      FMT_R: begin
        oDEC.rd     = ins[11:7];
        oDEC.rs1    = ins[19:15];
        oDEC.rs2    = ins[24:20];
        oDEC.funct3 = ins[14:12];
        oDEC.funct7 = ins[31:25];
      end
      FMT_I: begin
        oDEC.rd     = ins[11:7];
        oDEC.rs1    = ins[19:15];
        oDEC.funct3 = ins[14:12];
        oDEC.imm    = {{20{ins[31]}}, ins[31:20]};
      end
      FMT_S: begin
        oDEC.rs1    = ins[19:15];
        oDEC.rs2    = ins[24:20];
        oDEC.funct3 = ins[14:12];
        oDEC.imm    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      FMT_B: begin
        oDEC.rs1    = ins[19:15];
        oDEC.rs2    = ins[24:20];
        oDEC.funct3 = ins[14:12];
        oDEC.imm    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      FMT_U: begin
        oDEC.rd     = ins[11:7];
        oDEC.imm    = {ins[31:12], 12'b0};
      end
      FMT_J: begin
        oDEC.rd     = ins[11:7];
        oDEC.imm    = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      // unsupported opcode: every field stays zero, only the flag is raised
      default: oDEC.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides.
// DECODE_SKID_EN adds a skid entry and makes oREADY a registered output.
module instr_decode_stage
  import riscv_defs::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFLUSH,
  input  logic        iVALID,
  output logic        oREADY,
  input  logic [31:0] iINSTR,
  input  logic [31:0] iPC,
  output logic        oVALID,
  input  logic        iREADY,
  output logic [6:0]  oOPCODE,
  output logic [2:0]  oFMT,
  output logic [4:0]  oRD,
  output logic [4:0]  oRS1,
  output logic [4:0]  oRS2,
  output logic [2:0]  oFUNCT3,
  output logic [6:0]  oFUNCT7,
  output logic [31:0] oIMM,
  output logic [31:0] oPC,
  output logic        oILLEGAL,
  output logic [15:0] oILL_CNT
);

  dec_t        dec;
  entry_t      inEntry;
  entry_t      outReg;
  logic        outVld;
  logic        accept;
  logic [15:0] illCnt;

  instr_field_decode uFieldDec (
    .iINSTR (iINSTR),
    .oDEC   (dec)
  );

  assign inEntry = '{opcode: iINSTR[6:0], dec: dec, pc: iPC};
  // a beat offered during flush is dropped entirely
  assign accept  = iVALID & oREADY & ~iFLUSH;

`ifdef DECODE_SKID_EN
  entry_t skidReg;
  logic   skidVld;

  assign oREADY = ~skidVld;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      outVld  <= 1'b0;
      outReg  <= '0;
      skidVld <= 1'b0;
      skidReg <= '0;
    end else if (iFLUSH) begin
      outVld  <= 1'b0;
      skidVld <= 1'b0;
    end else if (!outVld || iREADY) begin
      // output slot frees up: skid entry first so ordering is kept
      if (skidVld) begin
        outReg  <= skidReg;
        outVld  <= 1'b1;
        skidVld <= 1'b0;
      end else if (accept) begin
        outReg  <= inEntry;
        outVld  <= 1'b1;
      end else begin
        outVld  <= 1'b0;
      end
    end else if (accept) begin
      skidReg <= inEntry;
      skidVld <= 1'b1;
    end
  end
`else
  assign oREADY = ~outVld | iREADY;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      outVld <= 1'b0;
      outReg <= '0;
    end else if (iFLUSH) begin
      outVld <= 1'b0;
    end else if (accept) begin
      outReg <= inEntry;
      outVld <= 1'b1;
    end else if (iREADY) begin
      outVld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge iCLK) begin
    if (iRST)
      illCnt <= '0;
    else if (accept && inEntry.dec.illegal && illCnt != 16'hFFFF)
      illCnt <= illCnt + 16'd1;
  end

  assign oVALID   = outVld;
  assign oOPCODE  = outReg.opcode;
  assign oFMT     = outReg.dec.fmt;
  assign oRD      = outReg.dec.rd;
  assign oRS1     = outReg.dec.rs1;
  assign oRS2     = outReg.dec.rs2;
  assign oFUNCT3  = outReg.dec.funct3;
  assign oFUNCT7  = outReg.dec.funct7;
  assign oIMM     = outReg.dec.imm;
  assign oPC      = outReg.pc;
  assign oILLEGAL = outReg.dec.illegal;
  assign oILL_CNT = illCnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; expectations are hand-encoded RV32I
// words. Stall expectations follow DECODE_SKID_EN when it is defined.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, iValid, oReady, oValid, iReady, oIllegal;
  logic [31:0] instr, pc, oImm, oPc;
  logic [6:0]  oOpcode, oFunct7;
  logic [2:0]  oFmt, oFunct3;
  logic [4:0]  oRd, oRs1, oRs2;
  logic [15:0] oIllCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .iCLK(clk), .iRST(rst), .iFLUSH(flush), .iVALID(iValid), .oREADY(oReady),
    .iINSTR(instr), .iPC(pc), .oVALID(oValid), .iREADY(iReady),
    .oOPCODE(oOpcode), .oFMT(oFmt), .oRD(oRd), .oRS1(oRs1), .oRS2(oRs2),
    .oFUNCT3(oFunct3), .oFUNCT7(oFunct7), .oIMM(oImm), .oPC(oPc),
    .oILLEGAL(oIllegal), .oILL_CNT(oIllCnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] stream [3];
  logic [31:0] w;
  logic [31:0] expCnt;
  logic        acc;
  int          idx, got, bad;

  initial begin
    vecs[0] = '{32'h002081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0};          // add x3,x1,x2
    vecs[1] = '{32'hFFF00293, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF};   // addi x5,x0,-1
    vecs[2] = '{32'h0020A423, 3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h8};          // sw x2,8(x1)
    vecs[3] = '{32'hFE208EE3, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC};   // beq x1,x2,-4
    vecs[4] = '{32'h40628233, 3'd0, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'h0};          // sub x4,x5,x6
    vecs[5] = '{32'h123453B7, 3'd4, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000};   // lui x7,0x12345
    vecs[6] = '{32'hFFFFF06F, 3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFE};   // jal x0,-2
    vecs[7] = '{32'hFF012403, 3'd1, 5'd8, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFFFFF0};   // lw x8,-16(x2)
    stream[0] = 32'h00100093; stream[1] = 32'h00100113; stream[2] = 32'h00100193;

    rst = 1'b1; flush = 1'b0; iValid = 1'b0; iReady = 1'b1; instr = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rstValid", oValid, 0);
    chk("rstReady", oReady, 1);
    chk("rstCnt", oIllCnt, 0);
    chk("rstImm", oImm, 0);
    chk("rstRd", oRd, 0);
    chk("rstPc", oPc, 0);

    // one instruction at a time, checked one cycle after acceptance
    for (int i = 0; i < 8; i++) begin
      w = vecs[i].ins;
      iValid = 1'b1; instr = w; pc = 32'h1000 + 32'(i * 4);
      @(posedge clk); #1;
      iValid = 1'b0;
      chk($sformatf("v%0d.valid", i), oValid, 1);
      chk($sformatf("v%0d.op", i), oOpcode, w[6:0]);
      chk($sformatf("v%0d.fmt", i), oFmt, vecs[i].fmt);
      chk($sformatf("v%0d.rd", i), oRd, vecs[i].rd);
      chk($sformatf("v%0d.rs1", i), oRs1, vecs[i].rs1);
      chk($sformatf("v%0d.rs2", i), oRs2, vecs[i].rs2);
      chk($sformatf("v%0d.f3", i), oFunct3, vecs[i].f3);
      chk($sformatf("v%0d.f7", i), oFunct7, vecs[i].f7);
      chk($sformatf("v%0d.imm", i), oImm, vecs[i].imm);
      chk($sformatf("v%0d.pc", i), oPc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d.ill", i), oIllegal, 0);
    end
    @(posedge clk); #1;
    chk("idleValid", oValid, 0);

    // back-to-back at full rate
    for (int k = 0; k < 3; k++) begin
      iValid = 1'b1; instr = vecs[k].ins;
      @(posedge clk); #1;
      chk($sformatf("thr%0d.valid", k), oValid, 1);
      chk($sformatf("thr%0d.rd", k), oRd, vecs[k].rd);
    end
    iValid = 1'b0;
    @(posedge clk); #1;
    chk("thrDrained", oValid, 0);

    // downstream stall for three cycles while I0..I2 are offered
    iReady = 1'b0; idx = 0;
    for (int c = 0; c < 3; c++) begin
      iValid = 1'b1; instr = stream[idx];
      #1;
`ifdef DECODE_SKID_EN
      chk($sformatf("stallRdy%0d", c), oReady, (c < 2) ? 1 : 0);
`else
      chk($sformatf("stallRdy%0d", c), oReady, (c < 1) ? 1 : 0);
`endif
      acc = oReady;
      @(posedge clk); #1;
      if (acc) idx++;
    end
`ifdef DECODE_SKID_EN
    chk("stallAccepted", idx, 2);
`else
    chk("stallAccepted", idx, 1);
`endif
    chk("stallHeadValid", oValid, 1);
    chk("stallHeadRd", oRd, 1);

    iReady = 1'b1; got = 0;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      iValid = (idx < 3);
      instr  = stream[(idx < 3) ? idx : 0];
      #1;
      acc = iValid & oReady;
      if (oValid) begin
        chk($sformatf("drain%0d.rd", got), oRd, got + 1);
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    iValid = 1'b0;
    chk("drainCount", got, 3);
    @(posedge clk); #1;
    chk("drainEmpty", oValid, 0);

    // illegal beat during flush is dropped and not counted
    flush = 1'b1; iValid = 1'b1; instr = 32'hFFFFFFFF;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flushDropValid", oValid, 0);
    chk("flushDropCnt", oIllCnt, 0);
    @(posedge clk); #1;
    iValid = 1'b0;
    chk("illValid", oValid, 1);
    chk("illFlag", oIllegal, 1);
    chk("illFmt", oFmt, 7);
    chk("illImm", oImm, 0);
    chk("illRd", oRd, 0);
    chk("illRs1", oRs1, 0);
    chk("illF3", oFunct3, 0);
    chk("illCnt1", oIllCnt, 1);

    // illegal stream to saturation
    iValid = 1'b1; instr = 32'hFFFFFFFF; iReady = 1'b1; expCnt = 1; bad = 0;
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clk); #1;
      if (expCnt != 32'hFFFF) expCnt++;
      if (oIllegal !== 1'b1 || oValid !== 1'b1) bad++;
      if (n == 1000 || n == 65533 || n == 65534 || n == 70000)
        chk($sformatf("illCnt@%0d", n), oIllCnt, expCnt);
    end
    chk("illEach", bad, 0);

    // flush with an entry pending keeps the counter
    iReady = 1'b0; flush = 1'b1; instr = vecs[0].ins;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flushValid", oValid, 0);
    chk("flushCnt", oIllCnt, 16'hFFFF);

    // reset wins over flush and drops a pending entry
    @(posedge clk); #1;
    chk("pendValid", oValid, 1);
    iValid = 1'b0; rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    chk("midRstValid", oValid, 0);
    chk("midRstCnt", oIllCnt, 0);
    chk("midRstRd", oRd, 0);
    @(posedge clk); #1;
    chk("postRstReady", oReady, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered decode stage feeding the per-format datapath. It accepts raw 32-bit RV32I instruction words with a valid/ready handshake and classifies each by opcode into R/I/S/B/U/J. It extracts register indices, funct fields and the sign-extended immediate, and presents them one cycle later to the opcode-steered routing logic. It is the producing end of the OPCODE/rd/rs1/rs2 interface that the routing mux consumes.

## Interface
- No parameters; widths fixed by RV32I.
- iCLK  input  1  single clock; all state updates on rising edge.
- iRST  input  1  reset, synchronous, active-high.
- iFLUSH  input  1  synchronous pipeline flush.
- iVALID  input  1  upstream instruction valid.
- oREADY  output  1  stage can accept an instruction.
- iINSTR  input  32  raw instruction word.
- iPC  input  32  PC of iINSTR.
- oVALID  output  1  decoded entry valid.
- iREADY  input  1  downstream accepts the entry.
- oOPCODE  output  7  instr[6:0].
- oFMT  output  3  format code (package constants).
- oRD, oRS1, oRS2  output  5 each  register indices; 0 where the format has no such field.
- oFUNCT3  output  3  instr[14:12]; 0 for U/J.
- oFUNCT7  output  7  instr[31:25] for R; otherwise 0.
- oIMM  output  32  sign-extended immediate; 0 for R.
- oPC  output  32  PC of the entry.
- oILLEGAL  output  1  opcode is not one of the nine supported opcodes.
- oILL_CNT  output  16  saturating count of accepted illegal instructions.

## Operation
- Opcode classes:
  - 0110011 → R.
  - 0010011, 0000011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Anything else → FMT_NONE: oILLEGAL=1, all fields and oIMM zero. The entry still flows through as valid.
- Field presence by format:
  - rd: R, I, U, J.
  - rs1: R, I, S, B.
  - rs2: R, S, B.
- Immediates follow standard RV32I encodings, sign-extended from instr[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Handshake:
  - Input beat transfers when iVALID & oREADY.
  - Output beat transfers when oVALID & iREADY.
  - Outputs hold stable while oVALID & !iREADY.
- oILL_CNT increments by 1 for each accepted illegal beat and saturates at 0xFFFF. It is cleared only by iRST; iFLUSH does not clear it.
- iFLUSH: all stored entries are discarded and oVALID=0 the next cycle. An input beat offered in the flush cycle is dropped and not counted.
- iRST has priority over iFLUSH.

## Timing
- Latency: 1 cycle from input acceptance to oVALID.
- Throughput: 1 instruction/cycle when iREADY is held high.
- Reset values: oVALID=0, all data outputs 0, oILL_CNT=0, oREADY=1 the cycle after reset is released.
- Reset mid-transfer: stored entries are lost and no beat is reported.
- Simultaneous accept and issue on a full output register: the new entry replaces the old with no bubble.

## Configuration
- Macro: DECODE_SKID_EN.
- Defined:
  - A second skid entry is added and oREADY is a register output, equal to "skid entry empty".
  - When downstream stalls, one extra beat is absorbed into the skid entry. oREADY drops the cycle after the skid entry fills.
  - When downstream resumes, the skid entry moves to the output register in order.
- Undefined:
  - Single output register; oREADY = !oVALID | iREADY, combinational from iREADY.

## Structure
- Shared package/header riscv_defs holds:
  - the opcode constants (nine values);
  - the FMT codes: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- Sub-module instr_field_decode: purely combinational, iINSTR → {fmt, rd, rs1, rs2, funct3, funct7, imm, illegal}.
- Top level holds the output/skid registers, the handshake logic and the counter.

## Test plan
- add x3,x1,x2 (0x002081B3), iREADY=1 → next cycle:
  - oVALID=1, oFMT=0, oRD=3, oRS1=1, oRS2=2, oIMM=0.
- addi x5,x0,-1 (0xFFF00293) → oFMT=1, oRD=5, oRS1=0, oRS2=0, oIMM=0xFFFFFFFF.
- sw x2,8(x1) (0x0020A423) → oFMT=2, oRD=0, oIMM=8.
- beq x1,x2,-4 (0xFE208EE3) → oFMT=3, oIMM=0xFFFFFFFC.
- Hold iREADY=0 for 3 cycles while iVALID=1 streams I0, I1, I2:
  - With DECODE_SKID_EN: I0 and I1 are accepted, oREADY=0 from the cycle after I1 is accepted, and I0, I1, I2 drain in order after iREADY=1.
  - Without the macro: only I0 is accepted.
- Illegal stream and flush:
  - 0xFFFFFFFF presented for 70000 accepted beats → oILLEGAL=1 on each, oILL_CNT saturates at 0xFFFF.
  - Then iFLUSH with an entry pending → oVALID=0 next cycle, counter unchanged.
